// File: rtl/multi_nozzle_filler.sv
// Batch bottle filler: conveyor indexes NOZZLES bottles, fills each to a pulse target, then moves the batch out.
// Outputs decode from registered state in the same cycle. Valve gating uses registered counts. No backpressure: inputs are sampled every clk.
module multi_nozzle_filler #(
   parameter int NOZZLES       = 4,
   parameter int TARGET_W      = 8,
   parameter int ALIGN_CYCLES  = 5,
   parameter int SETTLE_CYCLES = 4,
   parameter int FILL_TIMEOUT  = 255,
   parameter int MOVE_TIMEOUT  = 64,
   parameter int CNT_W         = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [NOZZLES-1:0]  bottle_sensor,
   input  logic [NOZZLES-1:0]  flow_pulse,
   input  logic [TARGET_W-1:0] fill_target,
   input  logic                exit_sensor,
   input  logic                jam_sensor,
   input  logic                estop,
   input  logic                fault_ack,
   output logic                conveyor_on,
   output logic [NOZZLES-1:0]  valve_open,
   output logic                alarm,
   output logic [1:0]          fault_code,
   output logic                busy,
   output logic [CNT_W-1:0]    bottle_count
);

   localparam int T_A    = (ALIGN_CYCLES > SETTLE_CYCLES) ? ALIGN_CYCLES : SETTLE_CYCLES;
   localparam int T_B    = (FILL_TIMEOUT > MOVE_TIMEOUT) ? FILL_TIMEOUT : MOVE_TIMEOUT;
   localparam int T_MAX  = (T_A > T_B) ? T_A : T_B;
   localparam int TMR_W  = $clog2(T_MAX + 1);
   localparam int SUM_W  = CNT_W + 5;

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_JAM   = 2'b01;
   localparam logic [1:0] FC_ESTOP = 2'b10;
   localparam logic [1:0] FC_FILL  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_ALIGN,
      S_FILL,
      S_SETTLE,
      S_MOVE_OUT,
      S_FAULT
   } state_t;

   state_t                            state_q, state_d;
   logic [TMR_W-1:0]                  tmr_q, tmr_d;
   logic [NOZZLES-1:0]                mask_q, mask_d;
   logic [TARGET_W-1:0]               tgt_q, tgt_d;
   logic [NOZZLES-1:0][TARGET_W-1:0]  cnt_q, cnt_d;
   logic [1:0]                        fault_code_q, fault_code_d;
   logic [CNT_W-1:0]                  count_q, count_d;

   logic [NOZZLES-1:0]                valve_vec;
   logic                              pending;
   logic [3:0]                        pop;
   logic [SUM_W-1:0]                  sum;

   // A valve stays open only while its nozzle is still below target.
   always_comb begin
      valve_vec = '0;
      pop       = '0;
      for (int i = 0; i < NOZZLES; i++) begin
         valve_vec[i] = (state_q == S_FILL) && mask_q[i] && (cnt_q[i] < tgt_q);
         pop          = pop + 4'(mask_q[i]);
      end
      pending = |valve_vec;
      sum     = SUM_W'(count_q) + SUM_W'(pop);
   end

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      tgt_d        = tgt_q;
      cnt_d        = cnt_q;
      fault_code_d = fault_code_q;
      count_d      = count_q;

      if (state_q == S_FILL) begin
         for (int i = 0; i < NOZZLES; i++) begin
            if (valve_vec[i] && flow_pulse[i] && (cnt_q[i] != {TARGET_W{1'b1}}))
               cnt_d[i] = cnt_q[i] + TARGET_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start && !estop)
               state_d = S_RUN;
         end
         S_RUN: begin
            if (&bottle_sensor)
               state_d = S_ALIGN;
            else if (!start)
               state_d = S_IDLE;
         end
         S_ALIGN: begin
            if (tmr_q == TMR_W'(ALIGN_CYCLES - 1)) begin
               mask_d  = bottle_sensor;
               tgt_d   = fill_target;
               cnt_d   = '0;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (!pending)
               state_d = S_SETTLE;
            else if (tmr_q == TMR_W'(FILL_TIMEOUT - 1)) begin
               state_d      = S_FAULT;
               fault_code_d = FC_FILL;
            end
         end
         S_SETTLE: begin
            if (tmr_q == TMR_W'(SETTLE_CYCLES - 1))
               state_d = S_MOVE_OUT;
         end
         S_MOVE_OUT: begin
            if (exit_sensor) begin
               if (sum > SUM_W'({CNT_W{1'b1}}))
                  count_d = '1;
               else
                  count_d = sum[CNT_W-1:0];
               state_d = start ? S_RUN : S_IDLE;
            end else if (tmr_q == TMR_W'(MOVE_TIMEOUT - 1)) begin
               state_d      = S_FAULT;
               fault_code_d = FC_JAM;
            end
         end
         S_FAULT: begin
            if (fault_ack && !estop && !jam_sensor) begin
               state_d      = S_IDLE;
               fault_code_d = FC_NONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Hard faults override whatever the state logic chose, including a batch completion.
      if (state_q != S_FAULT) begin
         if (estop) begin
            state_d      = S_FAULT;
            fault_code_d = FC_ESTOP;
            count_d      = count_q;
         end else if (jam_sensor) begin
            state_d      = S_FAULT;
            fault_code_d = FC_JAM;
            count_d      = count_q;
         end
      end

      if (state_d != state_q)
         tmr_d = '0;
      else if (tmr_q != {TMR_W{1'b1}})
         tmr_d = tmr_q + TMR_W'(1);
      else
         tmr_d = tmr_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         tmr_q        <= '0;
         mask_q       <= '0;
         tgt_q        <= '0;
         cnt_q        <= '0;
         fault_code_q <= FC_NONE;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         mask_q       <= mask_d;
         tgt_q        <= tgt_d;
         cnt_q        <= cnt_d;
         fault_code_q <= fault_code_d;
         count_q      <= count_d;
      end
   end

   assign conveyor_on  = (state_q == S_RUN) || (state_q == S_MOVE_OUT);
   assign valve_open   = valve_vec;
   assign alarm        = (state_q == S_FAULT);
   assign busy         = (state_q != S_IDLE) && (state_q != S_FAULT);
   assign fault_code   = fault_code_q;
   assign bottle_count = count_q;

endmodule

// File: tb/tb_multi_nozzle_filler.sv
// Directed bench for multi_nozzle_filler: full batches, dropped bottle, fill/move timeouts, fault priority, count saturation, async reset.
module tb_multi_nozzle_filler;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [3:0] bottle_sensor;
   logic [3:0] flow_pulse;
   logic [7:0] fill_target;
   logic       exit_sensor;
   logic       jam_sensor;
   logic       estop;
   logic       fault_ack;
   logic       conveyor_on;
   logic [3:0] valve_open;
   logic       alarm;
   logic [1:0] fault_code;
   logic       busy;
   logic [3:0] bottle_count;

   int checks = 0;
   int errors = 0;

   multi_nozzle_filler #(
      .NOZZLES(4), .TARGET_W(8), .ALIGN_CYCLES(5), .SETTLE_CYCLES(4),
      .FILL_TIMEOUT(20), .MOVE_TIMEOUT(64), .CNT_W(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .bottle_sensor(bottle_sensor),
      .flow_pulse(flow_pulse), .fill_target(fill_target), .exit_sensor(exit_sensor),
      .jam_sensor(jam_sensor), .estop(estop), .fault_ack(fault_ack),
      .conveyor_on(conveyor_on), .valve_open(valve_open), .alarm(alarm),
      .fault_code(fault_code), .busy(busy), .bottle_count(bottle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From IDLE, run one batch up to the first FILL cycle; late is the sensor value seen in ALIGN's last cycle.
   task automatic to_fill(input logic [7:0] tgt, input logic [3:0] late, input logic [3:0] flow);
      start         = 1'b1;
      bottle_sensor = 4'hF;
      fill_target   = tgt;
      flow_pulse    = flow;
      exit_sensor   = 1'b0;
      step();
      chk("run_conveyor", 32'(conveyor_on), 1);
      step();
      chk("align_conveyor", 32'(conveyor_on), 0);
      repeat (4) step();
      chk("align_last_valves", 32'(valve_open), 0);
      bottle_sensor = late;
      step();
   endtask

   // Continuous flow: FILL lasts tgt+1 cycles (1 if nothing to fill), then 4 SETTLE cycles, then MOVE_OUT.
   task automatic fill_to_move(input logic [7:0] tgt, input logic [3:0] late);
      int len;
      int open_cnt [4];
      int exp_cnt;
      len = (tgt == 8'd0 || late == 4'd0) ? 1 : int'(tgt) + 1;
      for (int i = 0; i < 4; i++) open_cnt[i] = 0;
      for (int c = 0; c < len; c++) begin
         for (int i = 0; i < 4; i++)
            if (valve_open[i]) open_cnt[i]++;
         step();
      end
      for (int i = 0; i < 4; i++) begin
         exp_cnt = late[i] ? int'(tgt) : 0;
         chk($sformatf("valve_open_cycles[%0d]", i), 32'(open_cnt[i]), 32'(exp_cnt));
      end
      repeat (3) step();
      chk("settle_conveyor", 32'(conveyor_on), 0);
      chk("settle_valves", 32'(valve_open), 0);
      chk("settle_busy", 32'(busy), 1);
      step();
      chk("move_conveyor", 32'(conveyor_on), 1);
   endtask

   task automatic exit_batch(input logic [3:0] exp_count);
      exit_sensor = 1'b1;
      start       = 1'b0;
      step();
      exit_sensor   = 1'b0;
      bottle_sensor = 4'h0;
      chk("bottle_count", 32'(bottle_count), 32'(exp_count));
      chk("idle_busy", 32'(busy), 0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; bottle_sensor = 4'h0; flow_pulse = 4'h0;
      fill_target = 8'd3; exit_sensor = 1'b0; jam_sensor = 1'b0; estop = 1'b0; fault_ack = 1'b0;
      repeat (2) step();
      chk("rst_conveyor", 32'(conveyor_on), 0);
      chk("rst_valves", 32'(valve_open), 0);
      chk("rst_alarm", 32'(alarm), 0);
      chk("rst_code", 32'(fault_code), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(bottle_count), 0);
      reset_n = 1'b1;
      step();

      // Full batch, target 3
      to_fill(8'd3, 4'hF, 4'hF);
      chk("fill_first_valves", 32'(valve_open), 32'h0F);
      fill_to_move(8'd3, 4'hF);
      exit_batch(4'd4);

      // Bottle 2 missing when the mask is latched
      to_fill(8'd3, 4'b1011, 4'hF);
      fill_to_move(8'd3, 4'b1011);
      exit_batch(4'd7);

      // Nozzle 1 never flows -> fill timeout after 20 FILL cycles
      to_fill(8'd3, 4'hF, 4'b1101);
      repeat (19) step();
      chk("fill_tmo_last_valves", 32'(valve_open), 32'h02);
      chk("fill_tmo_last_alarm", 32'(alarm), 0);
      step();
      chk("fill_tmo_alarm", 32'(alarm), 1);
      chk("fill_tmo_code", 32'(fault_code), 3);
      chk("fill_tmo_valves", 32'(valve_open), 0);
      chk("fill_tmo_conveyor", 32'(conveyor_on), 0);
      chk("fill_tmo_busy", 32'(busy), 0);
      step();
      chk("fault_code_held", 32'(fault_code), 3);
      start = 1'b0; fault_ack = 1'b1;
      step();
      fault_ack = 1'b0;
      chk("fill_tmo_ack_alarm", 32'(alarm), 0);
      chk("fill_tmo_ack_code", 32'(fault_code), 0);

      // estop and jam together in MOVE_OUT: estop wins, jam blocks ack
      to_fill(8'd3, 4'hF, 4'hF);
      fill_to_move(8'd3, 4'hF);
      start = 1'b0; estop = 1'b1; jam_sensor = 1'b1;
      step();
      chk("estop_code", 32'(fault_code), 2);
      chk("estop_alarm", 32'(alarm), 1);
      chk("estop_conveyor", 32'(conveyor_on), 0);
      estop = 1'b0; fault_ack = 1'b1;
      step();
      chk("jam_blocks_ack_alarm", 32'(alarm), 1);
      chk("jam_blocks_ack_code", 32'(fault_code), 2);
      jam_sensor = 1'b0;
      step();
      fault_ack = 1'b0;
      chk("estop_ack_alarm", 32'(alarm), 0);
      chk("estop_ack_code", 32'(fault_code), 0);
      chk("estop_not_counted", 32'(bottle_count), 7);
      bottle_sensor = 4'h0;

      // Zero target: one FILL cycle, no valve opens
      to_fill(8'd0, 4'hF, 4'hF);
      chk("tgt0_valves", 32'(valve_open), 0);
      fill_to_move(8'd0, 4'hF);
      exit_batch(4'd11);

      // Count saturation at 15
      to_fill(8'd3, 4'b0111, 4'hF);
      fill_to_move(8'd3, 4'b0111);
      exit_batch(4'd14);
      to_fill(8'd3, 4'hF, 4'hF);
      fill_to_move(8'd3, 4'hF);
      exit_batch(4'd15);

      // Reset mid-FILL closes valves without a clock edge
      to_fill(8'd3, 4'hF, 4'hF);
      step();
      chk("midfill_valves", 32'(valve_open), 32'h0F);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_valves", 32'(valve_open), 0);
      chk("async_rst_count", 32'(bottle_count), 0);
      chk("async_rst_busy", 32'(busy), 0);
      step();
      reset_n = 1'b1;
      start = 1'b0; bottle_sensor = 4'h0;
      step();

      // No exit_sensor for 64 MOVE_OUT cycles -> jam fault
      to_fill(8'd3, 4'hF, 4'hF);
      fill_to_move(8'd3, 4'hF);
      repeat (63) step();
      chk("move_tmo_last_conveyor", 32'(conveyor_on), 1);
      step();
      chk("move_tmo_alarm", 32'(alarm), 1);
      chk("move_tmo_code", 32'(fault_code), 1);
      start = 1'b0; fault_ack = 1'b1;
      step();
      fault_ack = 1'b0;
      chk("move_tmo_ack_code", 32'(fault_code), 0);
      chk("move_tmo_not_counted", 32'(bottle_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_nozzle_filler.md
MULTI_NOZZLE_FILLER -- requirements
Module: multi_nozzle_filler

Interface
REQ-001 Parameter NOZZLES, default 4: number of fill heads filled in parallel per batch (1..8).
REQ-002 Parameter TARGET_W, default 8: width of the flow-pulse fill target and per-nozzle counters.
REQ-003 Parameter ALIGN_CYCLES, default 5: cycles spent in ALIGN.
REQ-004 Parameter SETTLE_CYCLES, default 4: cycles spent in SETTLE.
REQ-005 Parameter FILL_TIMEOUT, default 255: maximum FILL cycles before a fill fault.
REQ-006 Parameter MOVE_TIMEOUT, default 64: maximum MOVE_OUT cycles awaiting exit_sensor before a jam fault.
REQ-007 Parameter CNT_W, default 16: width of bottle_count.
REQ-008 Ports SHALL be:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  level run enable.
- bottle_sensor  in  NOZZLES  bottle present under nozzle i.
- flow_pulse  in  NOZZLES  one flow-meter tick per high cycle, nozzle i.
- fill_target  in  TARGET_W  pulses per bottle.
- exit_sensor  in  1  batch has cleared the exit.
- jam_sensor  in  1  jam detected.
- estop  in  1  emergency stop.
- fault_ack  in  1  operator fault acknowledge.
- conveyor_on  out  1  conveyor motor.
- valve_open  out  NOZZLES  per-nozzle valve.
- alarm  out  1  fault indication.
- fault_code  out  2  00 none, 01 jam, 10 estop, 11 fill timeout.
- busy  out  1  high in every state except IDLE and FAULT.
- bottle_count  out  CNT_W  bottles completed.
REQ-009 All inputs SHALL be synchronous to clk; synchronisation is outside this block.

Function
REQ-010 States SHALL be IDLE, RUN, ALIGN, FILL, SETTLE, MOVE_OUT, FAULT; outputs SHALL be decoded from the current state and registers (Moore), with no input-to-output combinational path except as given in REQ-015.
REQ-011 IDLE -> RUN when start=1 and estop=0; all outputs are inactive.
REQ-012 RUN: conveyor_on=1. Transition to ALIGN when bottle_sensor is all ones. If start=0 and bottle_sensor is not all ones, transition to IDLE.
REQ-013 ALIGN: conveyor_on=0 for exactly ALIGN_CYCLES cycles. In the last ALIGN cycle, latch mask=bottle_sensor and tgt=fill_target, and clear all per-nozzle counters. Transition to FILL.
REQ-014 FILL: counter[i] increments (saturating) each cycle in which flow_pulse[i]=1 and valve_open[i]=1.
REQ-015 valve_open[i] = (state==FILL) & mask[i] & (counter[i] < tgt). A valve therefore closes in the cycle its count reaches tgt.
REQ-016 FILL -> SETTLE when no masked nozzle has counter < tgt. If tgt=0 or mask=0, FILL lasts exactly one cycle with all valves closed.
REQ-017 FILL cycle count reaching FILL_TIMEOUT with any masked nozzle incomplete: go to FAULT with code 11.
REQ-018 SETTLE: all outputs inactive for exactly SETTLE_CYCLES cycles, then go to MOVE_OUT.
REQ-019 MOVE_OUT: conveyor_on=1. On exit_sensor=1, bottle_count += popcount(mask), saturating at all ones, then go to RUN if start=1, else IDLE.
REQ-020 MOVE_OUT lasting MOVE_TIMEOUT cycles without exit_sensor: go to FAULT with code 01.
REQ-021 Fault priority, evaluated in every non-FAULT state including IDLE: estop (code 10) > jam_sensor (code 01) > timeouts. Fault entry takes effect on the next edge, and all valves and the conveyor are off from that cycle.
REQ-022 FAULT: alarm=1, conveyor_on=0, valve_open=0, and fault_code is held.
REQ-023 FAULT exits to IDLE only in a cycle with fault_ack=1, estop=0 and jam_sensor=0; fault_code clears to 00 on exit. A partially filled batch is abandoned and not counted.
REQ-024 State timers SHALL reset to 0 on every state entry. Timer widths SHALL cover the largest timeout parameter without wrap.

Reset
REQ-025 reset_n=0 SHALL asynchronously force: state IDLE, conveyor_on=0, valve_open=0, alarm=0, fault_code=00, busy=0, bottle_count=0, mask=0, and all counters and timers 0.
REQ-026 Reset mid-FILL SHALL close all valves immediately, without waiting for a clock edge.

Verification
REQ-027 NOZZLES=4, fill_target=3, all sensors present, flow_pulse=4'b1111 continuous -> each valve open exactly 3 cycles; SETTLE follows; exit_sensor gives bottle_count=4.
REQ-028 bottle_sensor drops to 4'b1011 during ALIGN's last cycle -> valve_open[2] never asserts; bottle_count increments by 3.
REQ-029 flow_pulse[1] held 0, FILL_TIMEOUT=20 -> FAULT, code 11, alarm=1, valves 0; fault_ack with sensors clear -> IDLE, code 00.
REQ-030 estop and jam_sensor asserted together during MOVE_OUT -> code 10; fault_ack while jam_sensor=1 stays in FAULT.
REQ-031 fill_target=0 -> FILL lasts one cycle and no valve opens.
REQ-032 reset_n pulsed low mid-FILL -> valve_open=0 asynchronously; bottle_count=0 after reset.
REQ-033 CNT_W=4 with the count at 14 and a 4-bottle batch -> bottle_count saturates at 15.
